linebuf_port_arbiter: RTL and testbench

Shares one single-port line-buffer RAM between two requesters in the scan doubler.
- Write requester: VIC pixel stream, hires x address plus 4-bit colour index. Writes are buffered in a small FIFO.
- Read requester: VGA/HDMI scan-out. Reads have priority and fixed latency.
- A starvation guard forces a write slot when the FIFO has been full too long.
- One instance sits in front of each of the two line buffers in the double-buffer pair.

---
 rtl/linebuf_port_arbiter_if.sv | 70 +++++++
 rtl/linebuf_port_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_linebuf_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/linebuf_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : linebuf_port_arbiter_if
//  Purpose  : Bundles the write-stream, read-stream, status and RAM-side
//             signals of one line-buffer port arbiter.
//  Modports : slave  - arbiter side (drives wr_ready, rd_*, overflow, ram_*)
//             master - client side (drives wr_*, rd_req/rd_addr, ovf_clr,
//                      ram_dout)
//  Options  : LINEBUF_ARB_STATS_EN adds stat_force_cnt / stat_ovf_cnt.
//  Revision : 1.0 - initial release
// ============================================================================
interface linebuf_port_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 4
);
    // Write requester (VIC pixel stream)
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    // Read requester (scan-out)
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;
    logic              rd_miss;
    // Status
    logic              overflow;
    logic              ovf_clr;
    // Single-port RAM
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
`ifdef LINEBUF_ARB_STATS_EN
    logic [15:0]       stat_force_cnt;
    logic [15:0]       stat_ovf_cnt;
`endif

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        output wr_ready,
        input  rd_req, rd_addr,
        output rd_data, rd_data_valid, rd_miss,
        output overflow,
        input  ovf_clr,
        output ram_we, ram_addr, ram_din,
        input  ram_dout
`ifdef LINEBUF_ARB_STATS_EN
        ,
        output stat_force_cnt, stat_ovf_cnt
`endif
    );

    modport master (
        output wr_valid, wr_addr, wr_data,
        input  wr_ready,
        output rd_req, rd_addr,
        input  rd_data, rd_data_valid, rd_miss,
        input  overflow,
        output ovf_clr,
        input  ram_we, ram_addr, ram_din,
        output ram_dout
`ifdef LINEBUF_ARB_STATS_EN
        ,
        input  stat_force_cnt, stat_ovf_cnt
`endif
    );
endinterface
`default_nettype wire

// File: rtl/linebuf_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : linebuf_port_arbiter
//  Purpose  : Shares one single-port line-buffer RAM between a buffered write
//             stream and a fixed-latency, high-priority read stream. A
//             starvation guard forces a write slot when the write FIFO has
//             been full while reads kept winning for STARVE_LIMIT cycles.
//  Ports    : clk_dot8x - dot clock x8, rising edge
//             rst       - asynchronous, active-high reset
//             bus       - linebuf_port_arbiter_if.slave (write stream,
//                         read stream, overflow status, RAM port)
//  Options  : LINEBUF_ARB_STATS_EN - adds saturating 16-bit counters of
//             forced writes and dropped writes.
//  Revision : 1.0 - initial release
// ============================================================================
module linebuf_port_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk_dot8x,
    input  logic                  rst,
    linebuf_port_arbiter_if.slave bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] c_DEPTH  = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0] c_STARVE = STV_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_READ  = 2'd1,
        GNT_WRITE = 2'd2,
        GNT_FORCE = 2'd3
    } grant_t;

    // ------------------------------------------------------------------
    // Write FIFO
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [STV_W-1:0]  r_starve;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_lost;
    grant_t            w_gnt;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;

    assign w_full      = (r_count == c_DEPTH);
    assign w_empty     = (r_count == '0);
    assign w_push      = bus.wr_valid && !w_full;
    assign w_head_addr = r_fifo_addr[r_rptr];
    assign w_head_data = r_fifo_data[r_rptr];

    assign bus.wr_ready = !w_full;

    // Storage carries no reset: emptiness is tracked by the pointers/count.
    always_ff @(posedge clk_dot8x) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= bus.wr_addr;
            r_fifo_data[r_wptr] <= bus.wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Grant selection (one RAM access per cycle)
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt = GNT_IDLE;
        if (!w_empty && (r_starve == c_STARVE)) begin
            w_gnt = GNT_FORCE;
        end else if (bus.rd_req) begin
            w_gnt = GNT_READ;
        end else if (!w_empty) begin
            w_gnt = GNT_WRITE;
        end
    end

    assign w_pop  = (w_gnt == GNT_FORCE) || (w_gnt == GNT_WRITE);
    // A read request that coincides with a forced write loses its slot.
    assign w_lost = (w_gnt == GNT_FORCE) && bus.rd_req;

    assign bus.ram_we   = w_pop;
    assign bus.ram_addr = w_pop ? w_head_addr : bus.rd_addr;
    assign bus.ram_din  = w_pop ? w_head_data : '0;

    // ------------------------------------------------------------------
    // FIFO pointers, occupancy and starvation counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_dot8x or posedge rst) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_starve <= '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally.
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // Fullness is judged on the occupancy before this cycle's pop.
            if (w_pop || !w_full) begin
                r_starve <= '0;
            end else if ((w_gnt == GNT_READ) && (r_starve != c_STARVE)) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline: stage 1 records the grant outcome while the RAM
    // performs its registered read; stage 2 captures the RAM output.
    // ------------------------------------------------------------------
    logic              r_s1_valid;
    logic              r_s1_miss;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_rd_miss;

    always_ff @(posedge clk_dot8x or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_miss  <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_miss  <= 1'b0;
        end else begin
            r_s1_valid <= (w_gnt == GNT_READ) || w_lost;
            r_s1_miss  <= w_lost;
            r_rd_valid <= r_s1_valid;
            r_rd_miss  <= r_s1_miss;
            // A lost read returns black; otherwise rd_data holds when idle.
            if (r_s1_valid) begin
                r_rd_data <= r_s1_miss ? '0 : bus.ram_dout;
            end
        end
    end

    assign bus.rd_data       = r_rd_data;
    assign bus.rd_data_valid = r_rd_valid;
    assign bus.rd_miss       = r_rd_miss;

    // ------------------------------------------------------------------
    // Sticky overflow: a new drop overrides a simultaneous clear.
    // ------------------------------------------------------------------
    logic r_overflow;
    logic w_drop;

    assign w_drop = bus.wr_valid && w_full;

    always_ff @(posedge clk_dot8x or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign bus.overflow = r_overflow;

`ifdef LINEBUF_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Saturating event counters, cleared together with overflow.
    // ------------------------------------------------------------------
    logic [15:0] r_stat_force;
    logic [15:0] r_stat_ovf;

    always_ff @(posedge clk_dot8x or posedge rst) begin
        if (rst) begin
            r_stat_force <= '0;
            r_stat_ovf   <= '0;
        end else if (bus.ovf_clr) begin
            r_stat_force <= '0;
            r_stat_ovf   <= '0;
        end else begin
            if ((w_gnt == GNT_FORCE) && (r_stat_force != 16'hFFFF)) begin
                r_stat_force <= r_stat_force + 16'd1;
            end
            if (w_drop && (r_stat_ovf != 16'hFFFF)) begin
                r_stat_ovf <= r_stat_ovf + 16'd1;
            end
        end
    end

    assign bus.stat_force_cnt = r_stat_force;
    assign bus.stat_ovf_cnt   = r_stat_ovf;
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_linebuf_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_linebuf_port_arbiter
//  Purpose  : Directed stimulus for linebuf_port_arbiter with a queue-based
//             scoreboard. The stimulus process pushes the expected RAM writes
//             and read results; a monitor pops and compares them whenever the
//             DUT asserts ram_we or rd_data_valid. Timing-specific items are
//             checked inline by the stimulus process.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_linebuf_port_arbiter;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 4;

    logic clk;
    logic rst;

    linebuf_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    linebuf_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .FIFO_DEPTH  (4),
        .STARVE_LIMIT(8)
    ) dut (
        .clk_dot8x (clk),
        .rst       (rst),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM model with registered read
    logic [DATA_W-1:0] mem [2**ADDR_W];
    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
        bus.ram_dout = '0;
    end
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    // Scoreboard
    typedef struct packed { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_t;
    typedef struct packed { logic [DATA_W-1:0] d; logic m; } rd_t;
    wr_t exp_wr [$];
    rd_t exp_rd [$];

    int n_cmp = 0;
    int n_err = 0;
    int n_wr_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ram_we) begin
                n_wr_seen++;
                if (exp_wr.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL ram_write_unexpected: got addr=%0d data=%0d, required no write (t=%0t)",
                             bus.ram_addr, bus.ram_din, $time);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("ram_write_addr", 32'(bus.ram_addr), 32'(e.a));
                    chk("ram_write_data", 32'(bus.ram_din), 32'(e.d));
                end
            end
            if (bus.rd_data_valid) begin
                if (exp_rd.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rd_result_unexpected: got data=%0d miss=%0d, required no result (t=%0t)",
                             bus.rd_data, bus.rd_miss, $time);
                end else begin
                    rd_t e;
                    e = exp_rd.pop_front();
                    chk("rd_data", 32'(bus.rd_data), 32'(e.d));
                    chk("rd_miss", 32'(bus.rd_miss), 32'(e.m));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_t e;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        e.a = a;
        e.d = d;
        exp_wr.push_back(e);
    endtask

    task automatic issue_rd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic m);
        rd_t e;
        bus.rd_req  = 1'b1;
        bus.rd_addr = a;
        e.d = d;
        e.m = m;
        exp_rd.push_back(e);
    endtask

    // Hard time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_req   = 1'b0;
        bus.rd_addr  = '0;
        bus.ovf_clr  = 1'b0;
        rst = 1'b0;

        // ---- 1: asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("reset_wr_ready",      32'(bus.wr_ready), 32'd1);
        chk("reset_ram_we",        32'(bus.ram_we), 32'd0);
        chk("reset_rd_data",       32'(bus.rd_data), 32'd0);
        chk("reset_rd_data_valid", 32'(bus.rd_data_valid), 32'd0);
        chk("reset_overflow",      32'(bus.overflow), 32'd0);
        chk("reset_rd_miss",       32'(bus.rd_miss), 32'd0);
        tick();
        tick();

        // ---- 2: three writes drain in order with no reads
        push_wr(11'd5, 4'd1);
        tick();
        push_wr(11'd6, 4'd2);
        tick();
        push_wr(11'd7, 4'd3);
        tick();
        bus.wr_valid = 1'b0;
        tick();
        chk("t2_fifo_empty_ram_we", 32'(bus.ram_we), 32'd0);
        chk("t2_wr_ready",          32'(bus.wr_ready), 32'd1);

        // ---- 3: read beats pending write; write follows next cycle
        push_wr(11'd9, 4'd4);
        tick();
        bus.wr_valid = 1'b0;
        issue_rd(11'd5, 4'd1, 1'b0);
        #1;
        chk("t3_read_wins_we",   32'(bus.ram_we), 32'd0);
        chk("t3_read_wins_addr", 32'(bus.ram_addr), 32'd5);
        tick();
        bus.rd_req = 1'b0;
        #1;
        chk("t3_write_next_we",   32'(bus.ram_we), 32'd1);
        chk("t3_write_next_addr", 32'(bus.ram_addr), 32'd9);
        tick();
        chk("t3_rd_valid_T2", 32'(bus.rd_data_valid), 32'd1);
        chk("t3_rd_data_T2",  32'(bus.rd_data), 32'd1);
        tick();

        // ---- 4: starvation guard (RAM[6]=2)
        for (int c = 0; c <= 12; c++) begin
            if (c < 4) push_wr(11'(10 + c), 4'(5 + c));
            else       bus.wr_valid = 1'b0;
            issue_rd(11'd6, (c == 12) ? 4'd0 : 4'd2, (c == 12));
            #1;
            chk("t4_ram_we", 32'(bus.ram_we), (c == 12) ? 32'd1 : 32'd0);
            if (c == 12) chk("t4_force_addr", 32'(bus.ram_addr), 32'd10);
            tick();
        end
        bus.rd_req = 1'b0;
        tick();
        chk("t4_rd_miss",       32'(bus.rd_miss), 32'd1);
        chk("t4_rd_miss_data",  32'(bus.rd_data), 32'd0);
        chk("t4_rd_miss_valid", 32'(bus.rd_data_valid), 32'd1);
        tick();
        tick();
        chk("t4_drained_ram_we", 32'(bus.ram_we), 32'd0);
        chk("t4_rd_data_hold",   32'(bus.rd_data), 32'd0);

        // ---- 5: overflow on a write offered while full (RAM[7]=3)
        for (int c = 0; c < 4; c++) begin
            push_wr(11'(20 + c), 4'(9 + c));
            issue_rd(11'd7, 4'd3, 1'b0);
            tick();
        end
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 11'd99;
        bus.wr_data  = 4'd15;
        issue_rd(11'd7, 4'd3, 1'b0);
        #1;
        chk("t5_wr_ready_full", 32'(bus.wr_ready), 32'd0);
        tick();
        bus.wr_valid = 1'b0;
        bus.rd_req   = 1'b0;
        chk("t5_overflow_set", 32'(bus.overflow), 32'd1);
        tick();
        chk("t5_overflow_held", 32'(bus.overflow), 32'd1);
        tick();
        tick();
        tick();
        tick();
        chk("t5_drained_ram_we", 32'(bus.ram_we), 32'd0);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("t5_overflow_clear", 32'(bus.overflow), 32'd0);
        tick();

        // ---- 6: asynchronous reset with FIFO entries and reads in flight
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 11'd30;
        bus.wr_data  = 4'd1;
        issue_rd(11'd5, 4'd1, 1'b0);
        tick();
        bus.wr_addr = 11'd31;
        bus.wr_data = 4'd2;
        issue_rd(11'd5, 4'd1, 1'b0);
        tick();
        bus.wr_valid = 1'b0;
        bus.rd_req   = 1'b0;
        rst = 1'b1;
        exp_wr.delete();
        exp_rd.delete();
        #1;
        chk("t6_rst_wr_ready",  32'(bus.wr_ready), 32'd1);
        chk("t6_rst_ram_we",    32'(bus.ram_we), 32'd0);
        chk("t6_rst_rd_valid",  32'(bus.rd_data_valid), 32'd0);
        chk("t6_rst_rd_data",   32'(bus.rd_data), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("t6_post_ram_we",   32'(bus.ram_we), 32'd0);
            chk("t6_post_rd_valid", 32'(bus.rd_data_valid), 32'd0);
        end
        chk("t6_post_wr_ready", 32'(bus.wr_ready), 32'd1);

        // ---- final scoreboard state
        chk("final_exp_wr_left", 32'(exp_wr.size()), 32'd0);
        chk("final_exp_rd_left", 32'(exp_rd.size()), 32'd0);
        chk("final_writes_seen", 32'(n_wr_seen), 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
